adc733_chan_accum: RTL

Per-channel sample accumulator placed directly downstream of `adc733_wrap`. It takes the parallel 16-bit sample stream that the wrapper deserialises from the codec (six interleaved channels: sin/cos pairs of three tones) and assigns each sample a channel index. Samples are summed per channel over a window bounded by `sync` pulses. At each `sync` the block snapshots the window and streams one {channel, sum, count} record per channel to the downstream processing stage over a valid/ready handshake.

---
 rtl/adc733_chan_accum.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/adc733_chan_accum.sv
// Per-channel windowed sample accumulator; sums interleaved ADC samples per channel between sync pulses.
// Latency: sample at t visible in live sums at t+1; sync at t gives first record (chan 0) at t+1.
// Backpressure: m_ready stalls only the record dump; samples never stall and keep accumulating.
module adc733_chan_accum #(
  parameter int NCH = 6,
  parameter int DW  = 16,
  parameter int AW  = 32,
  parameter int CW  = 16
) (
  input  logic          clk,
  input  logic          rst_l,
  input  logic          sync,
  input  logic          s_valid,
  input  logic [DW-1:0] s_data,
  input  logic          s_first,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [2:0]    m_chan,
  output logic [AW-1:0] m_sum,
  output logic [CW-1:0] m_cnt,
  output logic          m_last,
  output logic          overrun
);

  typedef enum logic {ST_IDLE, ST_DUMP} state_t;

  localparam logic [2:0]    LAST_CH = 3'(NCH - 1);
  localparam logic [AW-1:0] SAT_MAX = {1'b0, {(AW-1){1'b1}}};
  localparam logic [AW-1:0] SAT_MIN = {1'b1, {(AW-1){1'b0}}};

  // live window, snapshot of the previous window, channel pointer
  logic [AW-1:0] r_acc    [NCH];
  logic [CW-1:0] r_cnt    [NCH];
  logic [AW-1:0] r_sh_acc [NCH];
  logic [CW-1:0] r_sh_cnt [NCH];
  logic [2:0]    r_chp;

  // dump FSM and registered record outputs
  state_t        r_state;
  logic [2:0]    r_k;
  logic          r_m_valid;
  logic [2:0]    r_m_chan;
  logic [AW-1:0] r_m_sum;
  logic [CW-1:0] r_m_cnt;
  logic          r_m_last;
  logic          r_overrun;

  logic [2:0]    w_idx;
  logic [2:0]    w_chp_nxt;
  logic [AW:0]   w_samp_ext;
  logic [AW-1:0] w_acc_base [NCH];
  logic [CW-1:0] w_cnt_base [NCH];
  logic [AW:0]   w_sum      [NCH];
  logic [AW-1:0] w_acc_nxt  [NCH];
  logic [CW-1:0] w_cnt_nxt  [NCH];

  logic          w_accept;
  logic          w_last_acc;
  logic          w_snap;
  logic          w_ovr_set;
  state_t        w_state_nxt;
  logic [2:0]    w_k_nxt;
  logic          w_mv_nxt;
  logic [2:0]    w_chan_nxt;
  logic [AW-1:0] w_sum_nxt;
  logic [CW-1:0] w_cnt_out_nxt;
  logic          w_last_nxt;

  // s_first forces channel 0 so a slipped pointer realigns on the next frame
  assign w_idx      = s_first ? 3'd0 : r_chp;
  assign w_samp_ext = {{(AW + 1 - DW){s_data[DW-1]}}, s_data};

  // dump handshake; a sync that lands on the final acceptance is a clean restart, not an overrun
  assign w_accept   = (r_state == ST_DUMP) && m_ready;
  assign w_last_acc = w_accept && (r_k == LAST_CH);
  assign w_snap     = sync && ((r_state == ST_IDLE) || w_last_acc);
  assign w_ovr_set  = sync && (r_state == ST_DUMP) && !w_last_acc;

  // channel pointer advance with wrap
  always_comb begin
    w_chp_nxt = r_chp;
    if (s_valid) begin
      w_chp_nxt = (w_idx == LAST_CH) ? 3'd0 : w_idx + 3'd1;
    end
  end

  // live accumulators: clear on sync first, then add the same-cycle sample with saturation
  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      w_acc_base[i] = sync ? '0 : r_acc[i];
      w_cnt_base[i] = sync ? '0 : r_cnt[i];
      w_sum[i]      = {w_acc_base[i][AW-1], w_acc_base[i]} + w_samp_ext;
      w_acc_nxt[i]  = w_acc_base[i];
      w_cnt_nxt[i]  = w_cnt_base[i];
      if (s_valid && (w_idx == 3'(i))) begin
        if (w_sum[i][AW] != w_sum[i][AW-1]) begin
          w_acc_nxt[i] = w_sum[i][AW] ? SAT_MIN : SAT_MAX;
        end else begin
          w_acc_nxt[i] = w_sum[i][AW-1:0];
        end
        w_cnt_nxt[i] = (&w_cnt_base[i]) ? w_cnt_base[i] : w_cnt_base[i] + 1'b1;
      end
    end
  end

  // live and shadow register update
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_chp <= '0;
      for (int i = 0; i < NCH; i++) begin
        r_acc[i]    <= '0;
        r_cnt[i]    <= '0;
        r_sh_acc[i] <= '0;
        r_sh_cnt[i] <= '0;
      end
    end else begin
      r_chp <= w_chp_nxt;
      for (int i = 0; i < NCH; i++) begin
        r_acc[i] <= w_acc_nxt[i];
        r_cnt[i] <= w_cnt_nxt[i];
        if (w_snap) begin
          r_sh_acc[i] <= r_acc[i];
          r_sh_cnt[i] <= r_cnt[i];
        end
      end
    end
  end

  // FSM next state and next record contents
  always_comb begin
    w_state_nxt   = r_state;
    w_k_nxt       = r_k;
    w_mv_nxt      = 1'b0;
    w_chan_nxt    = '0;
    w_sum_nxt     = '0;
    w_cnt_out_nxt = '0;
    w_last_nxt    = 1'b0;
    if (w_snap) begin
      w_state_nxt = ST_DUMP;
      w_k_nxt     = '0;
    end else if (w_accept) begin
      if (r_k == LAST_CH) begin
        w_state_nxt = ST_IDLE;
        w_k_nxt     = '0;
      end else begin
        w_k_nxt = r_k + 3'd1;
      end
    end
    if (w_state_nxt == ST_DUMP) begin
      w_mv_nxt   = 1'b1;
      w_chan_nxt = w_k_nxt;
      w_last_nxt = (w_k_nxt == LAST_CH);
      // on a fresh snapshot the shadow is not loaded yet, so record 0 comes from the live window
      if (w_snap) begin
        w_sum_nxt     = r_acc[0];
        w_cnt_out_nxt = r_cnt[0];
      end else begin
        w_sum_nxt     = r_sh_acc[w_k_nxt];
        w_cnt_out_nxt = r_sh_cnt[w_k_nxt];
      end
    end
  end

  // FSM state, record output registers and sticky overrun
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_state   <= ST_IDLE;
      r_k       <= '0;
      r_m_valid <= 1'b0;
      r_m_chan  <= '0;
      r_m_sum   <= '0;
      r_m_cnt   <= '0;
      r_m_last  <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_k       <= w_k_nxt;
      r_m_valid <= w_mv_nxt;
      r_m_chan  <= w_chan_nxt;
      r_m_sum   <= w_sum_nxt;
      r_m_cnt   <= w_cnt_out_nxt;
      r_m_last  <= w_last_nxt;
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign m_valid = r_m_valid;
  assign m_chan  = r_m_chan;
  assign m_sum   = r_m_sum;
  assign m_cnt   = r_m_cnt;
  assign m_last  = r_m_last;
  assign overrun = r_overrun;

endmodule
